// File: rtl/wb_grf_pkg.sv
`default_nettype none
// ============================================================================
// Package : wb_grf_pkg
// Opcode/funct constants and shared typedefs for the write-back stage and GRF.
// Revision: 1.0
// ============================================================================
package wb_grf_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0a;
  localparam logic [5:0] c_op_ori   = 6'h0d;
  localparam logic [5:0] c_op_lui   = 6'h0f;
  localparam logic [5:0] c_op_lb    = 6'h20;
  localparam logic [5:0] c_op_lh    = 6'h21;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_lbu   = 6'h24;
  localparam logic [5:0] c_op_lhu   = 6'h25;

  // R-type function codes, instruction bits [5:0]
  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_jalr = 6'h09;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_slt  = 6'h2a;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_LINK = 2'd2
  } wr_src_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_kind_t;

endpackage
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
// Module : wb_load_ext
// Selects the byte/halfword of an aligned load word and sign/zero-extends it.
// Revision: 1.0
// ============================================================================
module wb_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  off,
  input  ld_kind_t    kind,
  output logic [31:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = dr[7:0];
    case (off)
      2'd0:    w_byte = dr[7:0];
      2'd1:    w_byte = dr[15:8];
      2'd2:    w_byte = dr[23:16];
      default: w_byte = dr[31:24];
    endcase
  end

  // off[0] plays no part in halfword selection; misalignment is trapped upstream
  assign w_half = off[1] ? dr[31:16] : dr[15:0];

  always_comb begin
    ext = dr;
    case (kind)
      LD_B:    ext = {{24{w_byte[7]}}, w_byte};
      LD_BU:   ext = {24'd0, w_byte};
      LD_H:    ext = {{16{w_half[15]}}, w_half};
      LD_HU:   ext = {16'd0, w_half};
      default: ext = dr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_grf.sv
`default_nettype none
// ============================================================================
// Module : wb_grf
// MIPS W stage: decodes the write, builds write data, and holds the 32x32 GRF
// with two combinational read ports. Define GRF_TRACE_EN for a write trace.
// Revision: 1.0
// ============================================================================
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int          BYPASS      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] DR_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_out,
  output logic [4:0]  WA_out,
  output logic [31:0] WD_out
);

  logic [31:0] r_regs [32];

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_we;
  logic [4:0]  w_wa;
  wr_src_t     w_src;
  ld_kind_t    w_kind;
  logic [31:0] w_load;
  logic [31:0] w_link;
  logic [31:0] w_wd;

  assign w_op = Instr_in[31:26];
  assign w_fn = Instr_in[5:0];
  assign w_rt = Instr_in[20:16];
  assign w_rd = Instr_in[15:11];

  always_comb begin
    w_we   = 1'b0;
    w_wa   = 5'd0;
    w_src  = SRC_ALU;
    w_kind = LD_W;
    case (w_op)
      c_op_rtype: begin
        case (w_fn)
          c_fn_addu, c_fn_subu, c_fn_sll, c_fn_slt: begin
            w_we = 1'b1;
            w_wa = w_rd;
          end
          c_fn_jalr: begin
            w_we  = 1'b1;
            w_wa  = w_rd;
            w_src = SRC_LINK;
          end
          default: w_we = 1'b0;
        endcase
      end
      c_op_ori, c_op_lui, c_op_addiu, c_op_slti: begin
        w_we = 1'b1;
        w_wa = w_rt;
      end
      c_op_lw, c_op_lb, c_op_lbu, c_op_lh, c_op_lhu: begin
        w_we  = 1'b1;
        w_wa  = w_rt;
        w_src = SRC_LOAD;
        case (w_op)
          c_op_lb:  w_kind = LD_B;
          c_op_lbu: w_kind = LD_BU;
          c_op_lh:  w_kind = LD_H;
          c_op_lhu: w_kind = LD_HU;
          default:  w_kind = LD_W;
        endcase
      end
      c_op_jal: begin
        w_we  = 1'b1;
        w_wa  = REG_RA;
        w_src = SRC_LINK;
      end
      default: w_we = 1'b0;
    endcase
    // Bubbles, $0 destinations and reset all collapse to a clean "no write"
    if (!reset_n || (Instr_in == 32'd0) || (w_wa == 5'd0)) begin
      w_we = 1'b0;
      w_wa = 5'd0;
    end
  end

  wb_load_ext u_load_ext (
    .dr   (DR_in),
    .off  (ALUout_in[1:0]),
    .kind (w_kind),
    .ext  (w_load)
  );

  assign w_link = PC_in + LINK_OFFSET;

  always_comb begin
    w_wd = 32'd0;
    if (w_we) begin
      case (w_src)
        SRC_LOAD: w_wd = w_load;
        SRC_LINK: w_wd = w_link;
        default:  w_wd = ALUout_in;
      endcase
    end
  end

  assign WE_out = w_we;
  assign WA_out = w_wa;
  assign WD_out = w_wd;

  // w_we already excludes $0, so r_regs[0] is never written after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_we) begin
      r_regs[w_wa] <= w_wd;
    end
  end

  always_comb begin
    RD1 = (RA1 == 5'd0) ? 32'd0 : r_regs[RA1];
    if ((BYPASS != 0) && w_we && (RA1 == w_wa)) begin
      RD1 = w_wd;
    end
  end

  always_comb begin
    RD2 = (RA2 == 5'd0) ? 32'd0 : r_regs[RA2];
    if ((BYPASS != 0) && w_we && (RA2 == w_wa)) begin
      RD2 = w_wd;
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset_n && w_we) begin
      $display("@%h: $%d <= %h", PC_in, w_wa, w_wd);
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_grf.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_grf
// Self-checking bench for wb_grf (BYPASS=1 and BYPASS=0 instances) with a
// behavioural register-file model and randomized W-stage traffic.
// Revision: 1.0
// ============================================================================
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] Instr_in, ALUout_in, DR_in, PC_in;
  logic [4:0]  RA1, RA2;
  logic [31:0] RD1, RD2, RD1_nb, RD2_nb;
  logic        WE_out, WE_nb;
  logic [4:0]  WA_out, WA_nb;
  logic [31:0] WD_out, WD_nb;

  always #5 clk = ~clk;

  wb_grf u_dut (
    .clk(clk), .reset_n(reset_n), .Instr_in(Instr_in), .ALUout_in(ALUout_in),
    .DR_in(DR_in), .PC_in(PC_in), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE_out(WE_out), .WA_out(WA_out), .WD_out(WD_out)
  );

  wb_grf #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .Instr_in(Instr_in), .ALUout_in(ALUout_in),
    .DR_in(DR_in), .PC_in(PC_in), .RA1(RA1), .RA2(RA2), .RD1(RD1_nb), .RD2(RD2_nb),
    .WE_out(WE_nb), .WA_out(WA_nb), .WD_out(WD_nb)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference state: architectural register contents and the expected write
  logic [31:0] mem [32];
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural meaning of a W-stage instruction, computed arithmetically
  task automatic predict(input logic [31:0] ins, alu, dr, pc);
    int unsigned op, fn, b, h;
    op = ins[31:26];
    fn = ins[5:0];
    b  = (dr >> (8 * alu[1:0])) & 32'hFF;
    h  = (dr >> (16 * alu[1])) & 32'hFFFF;
    exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
    if (op == 0 && (fn == 'h21 || fn == 'h23 || fn == 'h00 || fn == 'h2a)) begin
      exp_we = 1'b1; exp_wa = ins[15:11]; exp_wd = alu;
    end else if (op == 0 && fn == 'h09) begin
      exp_we = 1'b1; exp_wa = ins[15:11]; exp_wd = pc + 32'd8;
    end else if (op == 'h0d || op == 'h0f || op == 'h09 || op == 'h0a) begin
      exp_we = 1'b1; exp_wa = ins[20:16]; exp_wd = alu;
    end else if (op == 'h23) begin
      exp_we = 1'b1; exp_wa = ins[20:16]; exp_wd = dr;
    end else if (op == 'h20 || op == 'h24) begin
      exp_we = 1'b1; exp_wa = ins[20:16];
      exp_wd = (op == 'h20 && b >= 128) ? b - 256 : b;
    end else if (op == 'h21 || op == 'h25) begin
      exp_we = 1'b1; exp_wa = ins[20:16];
      exp_wd = (op == 'h21 && h >= 32768) ? h - 65536 : h;
    end else if (op == 'h03) begin
      exp_we = 1'b1; exp_wa = 5'd31; exp_wd = pc + 32'd8;
    end
    if (exp_wa == 0 || !reset_n) begin
      exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (byp && exp_we && a == exp_wa) return exp_wd;
    return (a == 0) ? 32'd0 : mem[a];
  endfunction

  task automatic apply(input logic [31:0] ins, alu, dr, pc);
    Instr_in = ins; ALUout_in = alu; DR_in = dr; PC_in = pc;
    predict(ins, alu, dr, pc);
    #1;
  endtask

  // Advance one edge and let the model commit what it predicted
  task automatic commit();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else if (exp_we) begin
      mem[exp_wa] = exp_wd;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; RA1 = 5'd5; RA2 = 5'd0;
    apply(rtype(5'd1, 5'd2, 5'd5, 6'h21), 32'h0000_0055, 32'd0, 32'h0000_3000);
    n_total++;
    if (WE_out !== 1'b0 || WA_out !== 5'd0 || WD_out !== 32'd0)
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h want 0/0/0", WE_out, WA_out, WD_out);
    else n_pass++;
    commit();
    commit();
    reset_n = 1'b1;
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD1 !== 32'd0) $display("FAIL reset_rd1: got %h want 00000000", RD1);
    else n_pass++;
    n_total++;
    if (WE_out !== 1'b0) $display("FAIL reset_bubble_we: got %b want 0", WE_out);
    else n_pass++;
  endtask

  task automatic test_alu();
    apply(itype(6'h0d, 5'd3, 5'd8, 16'h1234), 32'h0000_1234, 32'd0, 32'h100);
    n_total++;
    if (WE_out !== 1'b1 || WA_out !== 5'd8 || WD_out !== 32'h1234)
      $display("FAIL ori_write: got we=%b wa=%0d wd=%h want 1/8/00001234", WE_out, WA_out, WD_out);
    else n_pass++;
    commit();
    RA1 = 5'd8;
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD1 !== 32'h1234 || RD1_nb !== 32'h1234)
      $display("FAIL ori_read: got %h/%h want 00001234", RD1, RD1_nb);
    else n_pass++;
    apply(rtype(5'd1, 5'd2, 5'd0, 6'h21), 32'h0000_FFFF, 32'd0, 32'd0);
    n_total++;
    if (WE_out !== 1'b0 || WA_out !== 5'd0 || WD_out !== 32'd0)
      $display("FAIL zero_dest: got we=%b wa=%0d wd=%h want 0/0/0", WE_out, WA_out, WD_out);
    else n_pass++;
    commit();
    RA1 = 5'd0; RA2 = 5'd0;
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0) $display("FAIL zero_read: got %h/%h want 0", RD1, RD2);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [5:0]  ops  [5] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
    logic [1:0]  offs [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] want [5] = '{32'hFFFF_FF80, 32'h0000_0081, 32'hFFFF_8180,
                              32'h0000_7F01, 32'h8180_7F01};
    for (int i = 0; i < 5; i++) begin
      apply(itype(ops[i], 5'd2, 5'(10 + i), 16'd0), {30'h100, offs[i]}, 32'h8180_7F01, 32'd0);
      n_total++;
      if (WD_out !== want[i] || WA_out !== 5'(10 + i) || WE_out !== 1'b1)
        $display("FAIL load_%0d: got we=%b wa=%0d wd=%h want 1/%0d/%h", i, WE_out, WA_out,
                 WD_out, 10 + i, want[i]);
      else n_pass++;
      commit();
      RA1 = 5'(10 + i);
      apply(32'd0, 32'd0, 32'd0, 32'd0);
      n_total++;
      if (RD1 !== want[i]) $display("FAIL load_read_%0d: got %h want %h", i, RD1, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_link();
    apply({6'h03, 26'h0000C10}, 32'h0, 32'h0, 32'h0000_3008);
    commit();
    RA1 = 5'd31;
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD1 !== 32'h0000_3010) $display("FAIL jal_link: got %h want 00003010", RD1);
    else n_pass++;
    apply(rtype(5'd7, 5'd0, 5'd4, 6'h09), 32'h0, 32'h0, 32'hFFFF_FFFC);
    commit();
    RA2 = 5'd4;
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD2 !== 32'h0000_0004) $display("FAIL jalr_wrap: got %h want 00000004", RD2);
    else n_pass++;
  endtask

  task automatic test_bypass();
    apply(rtype(5'd1, 5'd2, 5'd9, 6'h21), 32'h1111_1111, 32'd0, 32'd0);
    commit();
    RA1 = 5'd9; RA2 = 5'd9;
    apply(rtype(5'd1, 5'd2, 5'd9, 6'h23), 32'hDEAD_BEEF, 32'd0, 32'd0);
    n_total++;
    if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'hDEAD_BEEF)
      $display("FAIL bypass_on: got %h/%h want deadbeef", RD1, RD2);
    else n_pass++;
    n_total++;
    if (RD1_nb !== 32'h1111_1111 || RD2_nb !== 32'h1111_1111)
      $display("FAIL bypass_off: got %h/%h want 11111111", RD1_nb, RD2_nb);
    else n_pass++;
    commit();
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    n_total++;
    if (RD1_nb !== 32'hDEAD_BEEF) $display("FAIL bypass_commit: got %h want deadbeef", RD1_nb);
    else n_pass++;
  endtask

  task automatic test_nonwriters();
    logic [31:0] ins [4];
    ins[0] = itype(6'h2b, 5'd1, 5'd8, 16'h0004);
    ins[1] = itype(6'h04, 5'd1, 5'd8, 16'h0004);
    ins[2] = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    ins[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      apply(ins[i], 32'hCAFE_0000 + i, 32'h5555_AAAA, 32'h400);
      n_total++;
      if (WE_out !== 1'b0 || WA_out !== 5'd0 || WD_out !== 32'd0)
        $display("FAIL nonwriter_%0d: got we=%b wa=%0d wd=%h want 0/0/0", i, WE_out, WA_out, WD_out);
      else n_pass++;
      commit();
    end
    apply(32'd0, 32'd0, 32'd0, 32'd0);
    for (int a = 0; a < 32; a++) begin
      RA1 = 5'(a); RA2 = 5'(31 - a);
      #1;
      n_total++;
      if (RD1 !== exp_rd(5'(a), 1'b1) || RD2 !== exp_rd(5'(31 - a), 1'b1))
        $display("FAIL array_%0d: got %h/%h want %h/%h", a, RD1, RD2,
                 exp_rd(5'(a), 1'b1), exp_rd(5'(31 - a), 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [5:0] iops [4] = '{6'h0d, 6'h0f, 6'h09, 6'h0a};
    logic [5:0] lops [5] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
    logic [5:0] fns  [6] = '{6'h21, 6'h23, 6'h00, 6'h2a, 6'h09, 6'h08};
    logic [5:0] nops [5] = '{6'h2b, 6'h28, 6'h29, 6'h04, 6'h05};
    logic [31:0] ins;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), fns[$urandom_range(0, 5)]);
        1: ins = itype(iops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 16'($urandom));
        2: ins = itype(lops[$urandom_range(0, 4)], 5'($urandom), 5'($urandom), 16'($urandom));
        3: ins = {6'h03, 26'($urandom)};
        4: ins = itype(nops[$urandom_range(0, 4)], 5'($urandom), 5'($urandom), 16'($urandom));
        default: ins = $urandom;
      endcase
      reset_n = ($urandom_range(0, 39) != 0);
      RA1 = 5'($urandom); RA2 = 5'($urandom);
      if ($urandom_range(0, 2) == 0) RA1 = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
      apply(ins, $urandom, $urandom, $urandom);
      n_total++;
      if (WE_out !== exp_we || WA_out !== exp_wa || WD_out !== exp_wd)
        $display("FAIL rand_write_%0d: ins=%h got %b/%0d/%h want %b/%0d/%h", n, ins,
                 WE_out, WA_out, WD_out, exp_we, exp_wa, exp_wd);
      else n_pass++;
      n_total++;
      if (RD1 !== exp_rd(RA1, 1'b1) || RD2 !== exp_rd(RA2, 1'b1) ||
          RD1_nb !== exp_rd(RA1, 1'b0) || RD2_nb !== exp_rd(RA2, 1'b0))
        $display("FAIL rand_read_%0d: got %h %h %h %h want %h %h %h %h", n, RD1, RD2, RD1_nb,
                 RD2_nb, exp_rd(RA1, 1'b1), exp_rd(RA2, 1'b1), exp_rd(RA1, 1'b0), exp_rd(RA2, 1'b0));
      else n_pass++;
      commit();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    reset_n = 1'b0; RA1 = 5'd0; RA2 = 5'd0;
    Instr_in = 32'd0; ALUout_in = 32'd0; DR_in = 32'd0; PC_in = 32'd0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_bypass();
    test_nonwriters();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file (GRF) of the 5-stage MIPS pipeline.
- Consumes the W-stage pipeline register outputs: instruction, ALU result, memory read data, PC.
- Decodes the instruction to decide whether to write, which register to write and what value: ALU result, extended load data, or link PC.
- Provides two combinational read ports to the D stage with internal W→D bypass, and exports the write triple for hazard/forwarding logic.

Parameters:
- LINK_OFFSET, 8: value added to PC_in to form the link address for jal/jalr.
- BYPASS, 1: 1 = a read of the register being written this cycle returns the new data; 0 = returns the old array contents.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- Instr_in  input  32  W-stage instruction.
- ALUout_in  input  32  W-stage ALU result. Bits [1:0] are the byte offset for loads.
- DR_in  input  32  W-stage memory read word, aligned.
- PC_in  input  32  W-stage instruction address.
- RA1  input  5  D-stage read address 1 (rs).
- RA2  input  5  D-stage read address 2 (rt).
- RD1  output  32  read data 1.
- RD2  output  32  read data 2.
- WE_out  output  1  a write occurs this cycle (already forced 0 when the destination is $0).
- WA_out  output  5  destination register.
- WD_out  output  32  write data.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on reset_n: at a rising clk edge with reset_n=0, all 32 registers clear to 0 and the write is suppressed.
  - Reset mid-stream drops any in-flight W instruction.
- Register array:
  - 32×32. $0 reads 0 always and writes to it are discarded.
  - Write occurs at the rising clk edge when WE_out=1 and reset_n=1.
  - Write latency: 1 edge. Reads are combinational from the array.
- Bypass (BYPASS=1): if WE_out=1, WA_out!=0 and RAx==WA_out, then RDx=WD_out.
- Decode (opcode [31:26], funct [5:0]):
  - R-type op 0x00:
    - addu 0x21, subu 0x23, sll 0x00, slt 0x2a: write rd, ALU source.
    - jalr 0x09: write rd, link source.
    - jr 0x08: no write.
  - ori 0x0d, lui 0x0f, addiu 0x09, slti 0x0a: write rt, ALU source.
  - lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25: write rt, load source.
  - jal 0x03: write $31, link source.
  - All others (sw, sb, sh, beq, bne, j, unknown): no write.
  - Instr_in=0 (sll $0) is a bubble: WE_out=0.
- Sources:
  - ALU source: ALUout_in.
  - Link source: PC_in+LINK_OFFSET, mod 2^32.
  - Load source, with off=ALUout_in[1:0]:
    - lw: DR_in.
    - lb/lbu: byte DR_in[8·off+7 : 8·off], sign- or zero-extended.
    - lh/lhu: halfword at off[1] (0 → [15:0], 1 → [31:16]), sign- or zero-extended.
    - off[0] is ignored for halfwords; alignment is checked upstream.
- Outputs when not writing:
  - WE_out, WA_out and WD_out are combinational from the inputs; no output register.
  - When no write is decoded: WE_out=0, WA_out=0, WD_out=0.
  - During reset_n=0: WE_out=0, WA_out=0, WD_out=0.
  - After reset: RD1=RD2=0 for any address.

Optional Feature:
- GRF_TRACE_EN: when defined, each committed write with WA_out!=0 issues a simulation display at the edge, format "@%h: $%d <= %h" with PC_in, WA_out, WD_out.
- Without it: no display, and no trace logic is synthesized.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - write-source typedef {SRC_ALU, SRC_LOAD, SRC_LINK};
  - load-kind typedef {LD_W, LD_B, LD_BU, LD_H, LD_HU};
  - the constant REG_RA=31.
- One sub-module: wb_load_ext, pure combinational (DR_in, off, kind → extended word).

Test Plan:
- Reset: hold reset_n=0 one edge with a valid addu writing rd=5 → $5 stays 0, WE_out=0, RD1(RA1=5)=0.
- ALU writes: ori rt=8 with ALUout=0x0000_1234, then edge → RD1(8)=0x1234. Write to $0 (addu rd=0, ALU=0xFFFF) → RD(0)=0 and WE_out=0.
- Loads with DR_in=0x8180_7F01:
  - lb off=2 → 0xFFFF_FF80.
  - lbu off=3 → 0x0000_0081.
  - lh off=2 → 0xFFFF_8180.
  - lhu off=0 → 0x0000_7F01.
  - lw → 0x8180_7F01.
- Link writes:
  - jal with PC_in=0x0000_3008 → $31=0x0000_3010.
  - jalr rd=4 with PC_in=0xFFFF_FFFC → $4=0x0000_0004 (wrap).
- Bypass: same cycle, write $9=0xDEAD_BEEF with RA1=RA2=9 → RD1=RD2=0xDEAD_BEEF before the edge with BYPASS=1; old value with BYPASS=0.
- Non-writers: sw, beq, jr and Instr_in=0 → WE_out=0 and the array is unchanged across 4 edges.
